// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program-counter generator and fetch-slot tracker for the IF
// stage. Drives the synchronous 1-cycle instruction memory address and keeps a
// registered pc/valid pair aligned with the instruction on the memory output,
// handling boot, stall, redirect, illegal-address faults and a fetch counter.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    output logic [31:0] imem_pc_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc_plus4_o,
    output logic        if_valid_o,
    output logic        fault_o,
    output logic [31:0] fault_addr_o,
    output logic [31:0] fetch_count_o
);

    // One bit wider than an address so 4*IMEM_WORDS itself is representable
    localparam logic [32:0] MEM_BYTES = 33'(IMEM_WORDS) << 2;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FAULT
    } state_t;

    state_t      state;
    logic [31:0] pcPlus4;
    logic [31:0] runNext;
    logic        runNextOk;
    logic        targetOk;

    // A fetch address is usable only if word-aligned and inside the memory
    function automatic logic isLegal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && ({1'b0, addr} < MEM_BYTES);
    endfunction

    assign pcPlus4       = if_pc_o + 32'd4;
    assign if_pc_plus4_o = pcPlus4;
    assign runNextOk     = isLegal(runNext);
    assign targetOk      = isLegal(redirect_target_i);

    // Pick the address we would like to fetch next while running: a redirect
    // beats a stall, and a stall re-reads the current word so the memory
    // output stays put for decode.
    always_comb begin
        runNext = pcPlus4;
        if (redirect_i) begin
            runNext = redirect_target_i;
        end else if (stall_i) begin
            runNext = if_pc_o;
        end
    end

    // Memory address: during reset and boot we point at the reset vector.
    // An illegal candidate is never presented; instead the current pc is
    // re-read so the memory port only ever sees legal addresses.
    always_comb begin
        imem_pc_o = if_pc_o;
        if (rst) begin
            imem_pc_o = RESET_PC;
        end else begin
            case (state)
                BOOT:    imem_pc_o = RESET_PC;
                RUN:     if (runNextOk) imem_pc_o = runNext;
                FAULT:   if (redirect_i && targetOk) imem_pc_o = redirect_target_i;
                default: imem_pc_o = if_pc_o;
            endcase
        end
    end

    // Fetch-slot state machine. The registered pc tracks whatever address
    // was handed to the memory last edge, so it always names the word that
    // is on the memory output now. The counter counts instructions that
    // decode actually took: live, not stalled, not killed by a redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BOOT;
            if_pc_o       <= RESET_PC;
            if_valid_o    <= 1'b0;
            fault_o       <= 1'b0;
            fault_addr_o  <= 32'h0;
            fetch_count_o <= 32'h0;
        end else begin
            if (if_valid_o && !stall_i && !redirect_i) begin
                fetch_count_o <= fetch_count_o + 32'd1;
            end
            case (state)
                BOOT: begin
                    if_pc_o    <= RESET_PC;
                    if_valid_o <= 1'b1;
                    state      <= RUN;
                end
                RUN: begin
                    if (runNextOk) begin
                        if_pc_o    <= runNext;
                        if_valid_o <= 1'b1;
                    end else begin
                        if_valid_o   <= 1'b0;
                        fault_o      <= 1'b1;
                        fault_addr_o <= runNext;
                        state        <= FAULT;
                    end
                end
                FAULT: begin
                    if (redirect_i) begin
                        if (targetOk) begin
                            if_pc_o    <= redirect_target_i;
                            if_valid_o <= 1'b1;
                            fault_o    <= 1'b0;
                            state      <= RUN;
                        end else begin
                            fault_addr_o <= redirect_target_i;
                        end
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: drives two fetch units (full-size and a 16-word memory)
// with shared directed and randomized stimulus, models a synchronous 1-cycle
// instruction memory for each, and compares every cycle against a
// behavioural reference of the fetch rules.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] tgt;

    logic [31:0] imemPcA, pcA, pcPlus4A, faultAddrA, countA, instrA;
    logic        validA, faultA;
    logic [31:0] imemPcB, pcB, pcPlus4B, faultAddrB, countB, instrB;
    logic        validB, faultB;

    logic [31:0] mem [0:1023];
    bit          armed;
    int          compared;
    int          mismatched;

    typedef struct packed {
        logic        boot;
        logic        flt;
        logic [31:0] pc;
        logic        vld;
        logic [31:0] faddr;
        logic [31:0] cnt;
    } mdl_t;

    mdl_t mA;
    mdl_t mB;

    fetch_pc_unit #(.RESET_PC(32'h0), .IMEM_WORDS(1024)) dutA (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redir),
        .redirect_target_i(tgt), .imem_pc_o(imemPcA), .if_pc_o(pcA),
        .if_pc_plus4_o(pcPlus4A), .if_valid_o(validA), .fault_o(faultA),
        .fault_addr_o(faultAddrA), .fetch_count_o(countA)
    );

    fetch_pc_unit #(.RESET_PC(32'h0), .IMEM_WORDS(16)) dutB (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redir),
        .redirect_target_i(tgt), .imem_pc_o(imemPcB), .if_pc_o(pcB),
        .if_pc_plus4_o(pcPlus4B), .if_valid_o(validB), .fault_o(faultB),
        .fault_addr_o(faultAddrB), .fetch_count_o(countB)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memories: the word addressed this cycle
    // appears on the output after the edge
    always @(posedge clk) begin
        instrA <= mem[imemPcA[11:2]];
        instrB <= mem[imemPcB[11:2]];
    end

    function automatic bit legalAddr(input logic [31:0] a, input int unsigned words);
        return ((a % 4) == 0) && (longint'(a) < 4 * longint'(words));
    endfunction

    // Reference: one clock edge of the fetch rules
    function automatic mdl_t step(input mdl_t m, input bit r, input bit st, input bit rd,
                                  input logic [31:0] t, input int unsigned words);
        mdl_t        n;
        logic [31:0] want;
        n = m;
        if (r) begin
            n = '{boot: 1'b1, flt: 1'b0, pc: 32'h0, vld: 1'b0, faddr: 32'h0, cnt: 32'h0};
            return n;
        end
        if (m.vld && !st && !rd) n.cnt = m.cnt + 32'd1;
        if (m.boot) begin
            n.boot = 1'b0;
            n.pc   = 32'h0;
            n.vld  = 1'b1;
        end else if (!m.flt) begin
            want = rd ? t : (st ? m.pc : m.pc + 32'd4);
            if (legalAddr(want, words)) begin
                n.pc = want;
            end else begin
                n.vld   = 1'b0;
                n.flt   = 1'b1;
                n.faddr = want;
            end
        end else if (rd) begin
            if (legalAddr(t, words)) begin
                n.pc  = t;
                n.vld = 1'b1;
                n.flt = 1'b0;
            end else begin
                n.faddr = t;
            end
        end
        return n;
    endfunction

    // Reference: memory address that must be presented this cycle
    function automatic logic [31:0] expImem(input mdl_t m, input bit r, input bit st, input bit rd,
                                            input logic [31:0] t, input int unsigned words);
        logic [31:0] want;
        if (r || m.boot) return 32'h0;
        if (m.flt) return (rd && legalAddr(t, words)) ? t : m.pc;
        want = rd ? t : (st ? m.pc : m.pc + 32'd4);
        return legalAddr(want, words) ? want : m.pc;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit d, input logic [31:0] t);
        rst   = r;
        stall = s;
        redir = d;
        tgt   = t;
        @(posedge clk);
        #1;
    endtask

    task automatic compareAll(input string tag, input mdl_t m, input logic [31:0] eImem,
                              input logic [31:0] imemPc, input logic [31:0] pc,
                              input logic [31:0] pcPlus4, input logic valid,
                              input logic flt, input logic [31:0] faddr,
                              input logic [31:0] cnt, input logic [31:0] instr);
        checkOutput({tag, ".imem_pc"}, imemPc, eImem);
        checkOutput({tag, ".if_pc"}, pc, m.pc);
        checkOutput({tag, ".pc_plus4"}, pcPlus4, m.pc + 32'd4);
        checkOutput({tag, ".valid"}, {31'b0, valid}, {31'b0, m.vld});
        checkOutput({tag, ".fault"}, {31'b0, flt}, {31'b0, m.flt});
        checkOutput({tag, ".fault_addr"}, faddr, m.faddr);
        checkOutput({tag, ".count"}, cnt, m.cnt);
        if (m.vld) checkOutput({tag, ".instr"}, instr, mem[m.pc[11:2]]);
    endtask

    // Advance both reference models at each edge from the sampled inputs
    always @(posedge clk) begin
        mA = step(mA, rst, stall, redir, tgt, 1024);
        mB = step(mB, rst, stall, redir, tgt, 16);
    end

    // Cycle-by-cycle comparison on the falling edge, after inputs and
    // registered outputs have settled
    always @(negedge clk) begin
        if (armed) begin
            compareAll("A", mA, expImem(mA, rst, stall, redir, tgt, 1024), imemPcA, pcA,
                       pcPlus4A, validA, faultA, faultAddrA, countA, instrA);
            compareAll("B", mB, expImem(mB, rst, stall, redir, tgt, 16), imemPcB, pcB,
                       pcPlus4B, validB, faultB, faultAddrB, countB, instrB);
        end
    end

    // Directed scenarios with literal expectations, then a randomized soak
    initial begin
        bit          r, s, d;
        logic [31:0] t;
        rst = 1'b1; stall = 1'b0; redir = 1'b0; tgt = 32'h0;
        armed = 1'b0; compared = 0; mismatched = 0;
        for (int i = 0; i < 1024; i++) mem[i] = {16'hA5C3, 16'(i)};
        mem[0] = 32'h00500093;
        mem[1] = 32'h00A00113;

        $display("[TB] reset and boot");
        applyStimulus(1, 0, 0, 32'h0);
        armed = 1'b1;
        applyStimulus(1, 0, 0, 32'h0);
        checkOutput("reset.valid", {31'b0, validA}, 32'd0);
        checkOutput("reset.count", countA, 32'd0);
        checkOutput("reset.imem", imemPcA, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("boot.pc", pcA, 32'h0);
        checkOutput("boot.valid", {31'b0, validA}, 32'd1);
        checkOutput("boot.instr", instrA, 32'h00500093);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("seq.pc", pcA, 32'h4);
        checkOutput("seq.count", countA, 32'd1);
        checkOutput("seq.instr", instrA, 32'h00A00113);
        applyStimulus(0, 0, 0, 32'h0);

        $display("[TB] stall");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 32'h0);
            checkOutput("stall.pc", pcA, 32'h8);
            checkOutput("stall.count", countA, 32'd2);
            checkOutput("stall.instr", instrA, {16'hA5C3, 16'd2});
        end
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("release.pc", pcA, 32'hC);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("release.pc2", pcA, 32'h10);
        checkOutput("release.count", countA, 32'd4);

        $display("[TB] redirect during stall");
        applyStimulus(0, 1, 1, 32'h40);
        checkOutput("redir.pc", pcA, 32'h40);
        checkOutput("redir.valid", {31'b0, validA}, 32'd1);
        checkOutput("redir.count", countA, 32'd4);

        $display("[TB] misaligned redirect");
        applyStimulus(0, 0, 1, 32'h42);
        checkOutput("mis.fault", {31'b0, faultA}, 32'd1);
        checkOutput("mis.faddr", faultAddrA, 32'h42);
        checkOutput("mis.valid", {31'b0, validA}, 32'd0);
        applyStimulus(0, 0, 0, 32'h0);
        applyStimulus(0, 1, 0, 32'h0);
        checkOutput("idle.fault", {31'b0, faultA}, 32'd1);
        checkOutput("idle.pc", pcA, 32'h40);
        checkOutput("idle.faddr", faultAddrA, 32'h42);
        applyStimulus(0, 0, 1, 32'h80);
        checkOutput("recover.pc", pcA, 32'h80);
        checkOutput("recover.valid", {31'b0, validA}, 32'd1);
        checkOutput("recover.fault", {31'b0, faultA}, 32'd0);
        checkOutput("recover.faddr", faultAddrA, 32'h42);
        checkOutput("small.faddr", faultAddrB, 32'h80);

        $display("[TB] fall off the end of memory");
        applyStimulus(0, 0, 1, 32'h38);
        checkOutput("fall.pc38", pcB, 32'h38);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("fall.pc3c", pcB, 32'h3C);
        checkOutput("fall.valid3c", {31'b0, validB}, 32'd1);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("fall.fault", {31'b0, faultB}, 32'd1);
        checkOutput("fall.faddr", faultAddrB, 32'h40);
        checkOutput("fall.pchold", pcB, 32'h3C);
        checkOutput("fall.bigpc", pcA, 32'h40);

        $display("[TB] reset mid-fault");
        applyStimulus(1, 0, 0, 32'h0);
        checkOutput("rstf.fault", {31'b0, faultB}, 32'd0);
        checkOutput("rstf.faddr", faultAddrB, 32'h0);
        checkOutput("rstf.count", countB, 32'd0);
        checkOutput("rstf.valid", {31'b0, validB}, 32'd0);
        checkOutput("rstf.imem", imemPcB, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("reboot.pc", pcB, 32'h0);
        checkOutput("reboot.valid", {31'b0, validB}, 32'd1);
        checkOutput("reboot.instr", instrB, 32'h00500093);

        $display("[TB] last word of full memory");
        applyStimulus(0, 0, 1, 32'hFF8);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("top.pc", pcA, 32'hFFC);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("top.fault", {31'b0, faultA}, 32'd1);
        checkOutput("top.faddr", faultAddrA, 32'h1000);
        checkOutput("top.pchold", pcA, 32'hFFC);

        $display("[TB] randomized soak");
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       t = 32'($urandom_range(0, 15)) << 2;
                1:       t = 32'($urandom_range(0, 1023)) << 2;
                2:       t = 32'($urandom_range(0, 67));
                default: t = $urandom;
            endcase
            applyStimulus(r, s, d, t);
        end
        applyStimulus(0, 0, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter generator and fetch-slot tracker for the IF stage of the RV32IM 5-stage pipeline. It drives the address port of the synchronous 1-cycle instruction memory. It registers the PC of the instruction currently on that memory's output, so decode receives a matched pc/instruction/valid triple. It handles stall, branch/jump redirect, boot after reset, and fetch-address faults (misaligned or out of range), and keeps a fetch counter.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; must be word-aligned and in range.
- IMEM_WORDS, 1024: instruction memory depth in 32-bit words; legal byte range is 0 .. 4*IMEM_WORDS-1.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  decode cannot accept; hold the current fetch slot.
- redirect_i  in  1  taken branch/jump from execute; overrides stall_i.
- redirect_target_i  in  32  redirect byte address.
- imem_pc_o  out  32  combinational address to the instruction memory pc port.
- if_pc_o  out  32  byte address of the instruction on the imem output this cycle.
- if_pc_plus4_o  out  32  if_pc_o + 4, mod 2^32, combinational.
- if_valid_o  out  1  imem output is a real, live instruction.
- fault_o  out  1  fetch halted on an illegal address.
- fault_addr_o  out  32  illegal address that caused the fault.
- fetch_count_o  out  32  instructions handed to decode since reset.

## Operation
- Legal address: addr[1:0]==2'b00 and addr < 4*IMEM_WORDS.
- States: BOOT, RUN, FAULT. Reset enters BOOT.
- BOOT: imem_pc_o = RESET_PC. stall_i and redirect_i are ignored. At the next edge: if_pc<=RESET_PC, if_valid<=1, state<=RUN.
- RUN, candidate address next:
  - redirect_i=1: next = redirect_target_i.
  - else stall_i=1: next = if_pc_o, so the imem re-reads the same word and its output is stable.
  - else: next = if_pc_o+4.
- RUN with next legal: imem_pc_o = next; at the edge if_pc<=next and if_valid stays 1.
- RUN with next illegal: imem_pc_o = if_pc_o. At the edge: if_valid<=0, fault_o<=1, fault_addr_o<=next, state<=FAULT. if_pc_o holds.
- FAULT:
  - if_valid_o=0; imem_pc_o = if_pc_o; stall_i is ignored.
  - redirect_i with a legal target: imem_pc_o = target. At the edge: if_pc<=target, if_valid<=1, fault_o<=0, state<=RUN. fault_addr_o keeps its last value.
  - redirect_i with an illegal target: stay in FAULT and update fault_addr_o.
- Redirect kills the instruction currently presented; it is not counted.
- fetch_count_o increments by 1 at every edge where if_valid_o=1, stall_i=0, redirect_i=0. It wraps modulo 2^32.
- Simultaneous redirect_i and stall_i: the redirect wins. Decode sees the target instruction in the next cycle, held while stall persists.

## Timing
- Any edge with rst=1:
  - state<=BOOT, if_pc<=RESET_PC, if_valid<=0, fault_o<=0, fault_addr_o<=0, fetch_count_o<=0.
  - imem_pc_o = RESET_PC while rst=1.
  - Reset has priority over everything, including reset taken mid-FAULT or mid-stall.
- Latency:
  - First valid instruction appears after the first edge with rst=0 (BOOT edge). The imem latches mem[RESET_PC] at that same edge.
  - Sequential fetch: 1 instruction per cycle, 0 bubbles.
  - Redirect: 0 bubbles. The target instruction is valid after the edge at which redirect_i=1 is sampled.
- imem_pc_o has a combinational path from redirect_i, redirect_target_i and stall_i.
- if_pc_o, if_valid_o, fault_o, fault_addr_o and fetch_count_o are registered.
- Address limits:
  - The fall-through increment from the last legal word faults on 4*IMEM_WORDS.
  - A sequential fetch never wraps to 0.

## Test plan
- Boot: mem[0]=32'h00500093, mem[1]=32'h00A00113; rst high 2 cycles, then low.
  - After edge 1: if_pc_o=0, if_valid_o=1, instruction=32'h00500093.
  - After edge 2: if_pc_o=4, fetch_count_o=1.
- Stall: stall_i=1 for 3 cycles while if_pc_o=8.
  - if_pc_o stays 8, instruction is unchanged, fetch_count_o is frozen.
  - After release: if_pc_o=32'hC, then 32'h10.
- Redirect during stall: stall_i=1, redirect_i=1, target 32'h40 at if_pc_o=32'h10.
  - Next cycle: if_pc_o=32'h40, if_valid_o=1, fetch_count_o unchanged.
- Misaligned redirect to 32'h42: next cycle fault_o=1, fault_addr_o=32'h42, if_valid_o=0.
  - Two idle cycles: no change.
  - Redirect to 32'h80: if_pc_o=32'h80, if_valid_o=1, fault_o=0.
- Fall-off with IMEM_WORDS=16: run from 32'h38.
  - 32'h3C is valid.
  - Next cycle: fault_o=1, fault_addr_o=32'h40, if_pc_o holds 32'h3C.
- Reset mid-fault: assert rst while fault_o=1.
  - All outputs return to reset values; the boot sequence repeats from RESET_PC.
